// File: rtl/fftcnn_pkg.sv
// Shared constants and state encoding for the FFT-domain convolution tile scheduler.
// Geometry is fixed here; run-time limits are parameters of the scheduler itself.
package fftcnn_pkg;

  localparam int DATALEN  = 16;
  localparam int FFTCHNL  = 8;
  localparam int CMPLXLEN = 2 * DATALEN;
  localparam int CIN      = 2;
  localparam int COUT     = 2;
  localparam int KPIX     = FFTCHNL * FFTCHNL;
  localparam int KADDR_W  = $clog2(KPIX);
  localparam int ROW_W    = $clog2(FFTCHNL);

  localparam int TILE_W_DEF   = 8;
  localparam int OUTBEATS_DEF = 8;
  localparam int TIMEOUT_DEF  = 1024;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_KLOAD = 2'd1,
    ST_ILOAD = 2'd2,
    ST_WAIT  = 2'd3
  } sched_state_e;

endpackage

// File: rtl/rd_strobe_pipe.sv
// Aligns a buffer read strobe with its registered read data and fans the word out.
// Data is forced to zero whenever valid is low so idle/reset outputs are clean.
module rd_strobe_pipe
  import fftcnn_pkg::*;
#(
  parameter int W   = CMPLXLEN,
  parameter int REP = 1
) (
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic           i_ren,
  input  logic [W-1:0]   i_rdata,
  output logic           o_valid,
  output logic [W*REP-1:0] o_data
);

  logic r_valid;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_valid <= 1'b0;
    end else begin
      r_valid <= i_ren;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_valid ? {REP{i_rdata}} : '0;

endmodule

// File: rtl/fft_conv_sched.sv
// Tile scheduler: loads the kernel spectrum once, then streams 8-row input tiles
// and collects output beats per tile, with a WAIT timeout and stray-beat flag.
//
// state    | meaning
// ---------+----------------------------------------------------------
// ST_IDLE  | waiting for start; zero-tile starts just pulse done
// ST_KLOAD | issuing kernel reads, addr 0..KPIX-1, one per clock
// ST_ILOAD | issuing input-row reads {tile,row}, row 0..FFTCHNL-1
// ST_WAIT  | collecting outvalid beats; timeout down-counter running
module fft_conv_sched
  import fftcnn_pkg::*;
#(
  parameter int TILE_W   = TILE_W_DEF,
  parameter int OUTBEATS = OUTBEATS_DEF,
  parameter int TIMEOUT  = TIMEOUT_DEF
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  input  logic [TILE_W-1:0]                 num_tiles,
  output logic                              busy,
  output logic                              done,
  output logic                              err,
  output logic                              ovf_err,
  output logic [KADDR_W-1:0]                krn_addr,
  output logic                              krn_ren,
  input  logic [CMPLXLEN-1:0]               krn_rdata,
  output logic [TILE_W+ROW_W-1:0]           in_addr,
  output logic                              in_ren,
  input  logic [FFTCHNL*CMPLXLEN-1:0]       in_rdata,
  output logic                              kvalid,
  output logic [CIN*COUT*CMPLXLEN-1:0]      kdata,
  output logic                              dvalid,
  output logic [CIN*FFTCHNL*CMPLXLEN-1:0]   ddata,
  input  logic                              outvalid,
  output logic [TILE_W-1:0]                 tile_idx
);

  localparam int BEAT_W = $clog2(OUTBEATS + 1);
  localparam int TMR_W  = $clog2(TIMEOUT + 1);

  localparam logic [KADDR_W-1:0] KADDR_LAST = KADDR_W'(KPIX - 1);
  localparam logic [ROW_W-1:0]   ROW_LAST   = ROW_W'(FFTCHNL - 1);
  localparam logic [BEAT_W-1:0]  BEATS_TGT  = BEAT_W'(OUTBEATS);
  localparam logic [TMR_W-1:0]   TMR_LOAD   = TMR_W'(TIMEOUT);

  sched_state_e       r_state;
  logic [TILE_W-1:0]  r_num_tiles;
  logic [TILE_W-1:0]  r_tile_idx;
  logic [KADDR_W-1:0] r_kaddr;
  logic [ROW_W-1:0]   r_row;
  logic [BEAT_W-1:0]  r_beats;
  logic [TMR_W-1:0]   r_tmr;
  logic               r_krn_ren;
  logic               r_in_ren;
  logic               r_busy;
  logic               r_done;
  logic               r_err;
  logic               r_ovf;

  logic               w_collecting;
  logic               w_beat_hit;
  logic [BEAT_W-1:0]  w_beats_nx;
  logic               w_beats_done;
  logic               w_last_tile;
  logic               w_stray;

  // Beats are accepted only while a tile is in the datapath and the quota is open.
  assign w_collecting = (r_state == ST_ILOAD) || (r_state == ST_WAIT);
  assign w_beat_hit   = outvalid && w_collecting && (r_beats < BEATS_TGT);
  assign w_beats_nx   = r_beats + {{(BEAT_W-1){1'b0}}, w_beat_hit};
  assign w_beats_done = (w_beats_nx == BEATS_TGT);
  assign w_last_tile  = (r_tile_idx == (r_num_tiles - TILE_W'(1)));
  assign w_stray      = outvalid &&
                        ((r_state == ST_IDLE) || (r_state == ST_KLOAD) ||
                         ((r_state == ST_WAIT) && (r_beats == BEATS_TGT)));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_num_tiles <= '0;
      r_tile_idx  <= '0;
      r_kaddr     <= '0;
      r_row       <= '0;
      r_beats     <= '0;
      r_tmr       <= '0;
      r_krn_ren   <= 1'b0;
      r_in_ren    <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_ovf       <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_stray) begin
        r_ovf <= 1'b1;
      end
      if (w_beat_hit) begin
        r_beats <= w_beats_nx;
      end

      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_err <= 1'b0;
            if (num_tiles == '0) begin
              r_done <= 1'b1;
            end else begin
              r_num_tiles <= num_tiles;
              r_tile_idx  <= '0;
              r_kaddr     <= '0;
              r_beats     <= '0;
              r_krn_ren   <= 1'b1;
              r_busy      <= 1'b1;
              r_state     <= ST_KLOAD;
            end
          end
        end

        ST_KLOAD: begin
          r_kaddr <= r_kaddr + KADDR_W'(1);
          if (r_kaddr == KADDR_LAST) begin
            r_krn_ren <= 1'b0;
            r_row     <= '0;
            r_in_ren  <= 1'b1;
            r_state   <= ST_ILOAD;
          end
        end

        ST_ILOAD: begin
          r_row <= r_row + ROW_W'(1);
          if (r_row == ROW_LAST) begin
            r_in_ren <= 1'b0;
            r_tmr    <= TMR_LOAD;
            r_state  <= ST_WAIT;
          end
        end

        ST_WAIT: begin
          // A completed quota wins over a timeout landing on the same cycle.
          if (w_beats_done) begin
            r_beats <= '0;
            if (w_last_tile) begin
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
              r_state <= ST_IDLE;
            end else begin
              r_tile_idx <= r_tile_idx + TILE_W'(1);
              r_row      <= '0;
              r_in_ren   <= 1'b1;
              r_state    <= ST_ILOAD;
            end
          end else if (r_tmr == '0) begin
            r_err   <= 1'b1;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end else begin
            r_tmr <= r_tmr - TMR_W'(1);
          end
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

  rd_strobe_pipe #(
    .W   (CMPLXLEN),
    .REP (CIN * COUT)
  ) u_kpipe (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_ren   (r_krn_ren),
    .i_rdata (krn_rdata),
    .o_valid (kvalid),
    .o_data  (kdata)
  );

  rd_strobe_pipe #(
    .W   (FFTCHNL * CMPLXLEN),
    .REP (CIN)
  ) u_dpipe (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_ren   (r_in_ren),
    .i_rdata (in_rdata),
    .o_valid (dvalid),
    .o_data  (ddata)
  );

  assign busy     = r_busy;
  assign done     = r_done;
  assign err      = r_err;
  assign ovf_err  = r_ovf;
  assign krn_addr = r_kaddr;
  assign krn_ren  = r_krn_ren;
  assign in_addr  = {r_tile_idx, r_row};
  assign in_ren   = r_in_ren;
  assign tile_idx = r_tile_idx;

endmodule

// File: tb/tb_fft_conv_sched.sv
// Bench for fft_conv_sched: a timeline model predicts every output per cycle from
// the run's start cycle, tile count and the fixed datapath latency.
module tb_fft_conv_sched;

  localparam int TO   = 32;
  localparam int KN   = 64;
  localparam int ROWS = 8;
  localparam int GAP  = 10;
  localparam int NB   = 8;
  // Tile period: last dvalid lands ROWS cycles after the first issue, then the
  // datapath gap, then NB beats; the next issue follows the last beat.
  localparam int TP   = ROWS + GAP + NB;

  logic         clk = 1'b0;
  logic         rst, start;
  logic [7:0]   num_tiles;
  logic         busy, done, err, ovf_err;
  logic [5:0]   krn_addr;
  logic         krn_ren;
  logic [31:0]  krn_rdata = '0;
  logic [10:0]  in_addr;
  logic         in_ren;
  logic [255:0] in_rdata = '0;
  logic         kvalid, dvalid;
  logic [127:0] kdata;
  logic [511:0] ddata;
  logic         outvalid;
  logic [7:0]   tile_idx;

  always #5 clk = ~clk;

  fft_conv_sched #(.TILE_W(8), .OUTBEATS(NB), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .start(start), .num_tiles(num_tiles),
    .busy(busy), .done(done), .err(err), .ovf_err(ovf_err),
    .krn_addr(krn_addr), .krn_ren(krn_ren), .krn_rdata(krn_rdata),
    .in_addr(in_addr), .in_ren(in_ren), .in_rdata(in_rdata),
    .kvalid(kvalid), .kdata(kdata), .dvalid(dvalid), .ddata(ddata),
    .outvalid(outvalid), .tile_idx(tile_idx)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s t=%0t got=%0h want=%0h", nm, $time, act, exp);
    end
  endtask

  function automatic logic [31:0] kpix(input int a);
    return {16'(a * 37 + 5), 16'(a) ^ 16'hA5A5};
  endfunction

  function automatic logic [255:0] inrow(input int r);
    logic [255:0] v;
    for (int j = 0; j < 8; j++) v[j*32 +: 32] = {16'(r * 16 + j), 16'(r * 8 + j) ^ 16'hF00F};
    return v;
  endfunction

  // Buffers with one-cycle registered read.
  always @(posedge clk) begin
    if (krn_ren) krn_rdata <= kpix(int'(krn_addr));
    if (in_ren)  in_rdata  <= inrow(int'(in_addr));
  end

  // Datapath stand-in: NB outvalid beats starting GAP cycles after the 8th dvalid.
  bit   dp_en = 1'b1;
  logic dp_ov = 1'b0;
  logic stray_ov = 1'b0;
  int   dv_cnt = 0, ov_delay = 0, ov_left = 0;
  assign outvalid = dp_ov | stray_ov;

  always @(negedge clk) begin
    dp_ov = 1'b0;
    if (rst) begin
      dv_cnt = 0; ov_delay = 0; ov_left = 0;
    end else begin
      if (ov_delay > 0) begin
        ov_delay--;
        if (ov_delay == 0) ov_left = NB;
      end
      if (ov_left > 0) begin
        dp_ov = 1'b1;
        ov_left--;
      end
      if (dvalid) begin
        dv_cnt++;
        if (dv_cnt == ROWS) begin
          dv_cnt = 0;
          if (dp_en) ov_delay = GAP;
        end
      end
    end
  end

  // Run descriptor: rel = cycle index relative to the cycle after start was sampled.
  int cyc = 0;
  bit run_active = 1'b0;
  int run_s = 0, run_n = 0;
  bit run_to = 1'b0;
  bit prev_err = 1'b0;
  bit m_ovf = 1'b0;
  bit chk_en = 1'b0;

  function automatic int end_rel();
    if (run_n == 0) return 0;
    if (run_to) return KN + ROWS + TO + 1;
    return KN + TP * run_n;
  endfunction

  function automatic bit cur_err(input int c);
    if (run_active && (c - run_s) >= 0) return run_to && ((c - run_s) >= end_rel());
    return prev_err;
  endfunction

  function automatic bit ov_ok(input int c);
    int rel;
    rel = c - run_s;
    return run_active && (run_n > 0) && (rel >= KN) && (rel < end_rel());
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      run_active = 1'b0;
      m_ovf      = 1'b0;
      prev_err   = 1'b0;
    end else if (outvalid && !ov_ok(cyc)) begin
      m_ovf = 1'b1;
    end
    cyc++;
  end

  int kv_seen = 0, dv_seen = 0, kr_seen = 0, ir_seen = 0, busy_seen = 0;
  int done_cnt = 0, last_done_rel = -1, last_in_addr = -1;

  always @(negedge clk) begin
    int rel, e, tt, off;
    logic x_busy, x_done, x_err, x_kren, x_kv, x_iren, x_dv;
    logic [5:0] x_kaddr;
    logic [10:0] x_iaddr;
    logic [7:0] x_tile;
    logic [127:0] x_kdata;
    logic [511:0] x_ddata;
    if (chk_en) begin
      x_busy = 0; x_done = 0; x_kren = 0; x_kv = 0; x_iren = 0; x_dv = 0;
      x_kaddr = '0; x_iaddr = '0; x_tile = '0; x_kdata = '0; x_ddata = '0;
      e = end_rel();
      rel = cyc - run_s;
      x_err = cur_err(cyc);
      if (run_active && rel >= 0) begin
        x_busy = (rel < e);
        x_done = (rel == e);
        if (run_n > 0 && rel < KN) begin
          x_kren = 1; x_kaddr = 6'(rel);
        end
        if (run_n > 0 && rel >= 1 && rel <= KN) begin
          x_kv = 1; x_kdata = {4{kpix(rel - 1)}};
        end
        if (rel >= KN && rel < e) begin
          tt = (rel - KN) / TP; off = (rel - KN) % TP;
          if (tt < run_n && off < ROWS) begin
            x_iren = 1; x_iaddr = 11'(tt * ROWS + off);
          end
        end
        if (rel >= KN + 1 && rel < e) begin
          tt = (rel - KN - 1) / TP; off = (rel - KN - 1) % TP;
          if (tt < run_n && off < ROWS) begin
            x_dv = 1; x_ddata = {2{inrow(tt * ROWS + off)}};
          end
        end
        if (rel < KN) x_tile = '0;
        else begin
          tt = (rel - KN) / TP;
          x_tile = 8'((tt < run_n) ? tt : run_n - 1);
        end
      end
      chk("busy", busy, x_busy);
      chk("done", done, x_done);
      chk("err", err, x_err);
      chk("ovf_err", ovf_err, m_ovf);
      chk("krn_ren", krn_ren, x_kren);
      chk("kvalid", kvalid, x_kv);
      chk("kdata", kdata, x_kdata);
      chk("in_ren", in_ren, x_iren);
      chk("dvalid", dvalid, x_dv);
      chk("ddata", ddata, x_ddata);
      if (x_kren) chk("krn_addr", krn_addr, x_kaddr);
      if (x_iren) chk("in_addr", in_addr, x_iaddr);
      if (x_busy) chk("tile_idx", tile_idx, x_tile);
      if (kvalid === 1'b1) kv_seen++;
      if (dvalid === 1'b1) dv_seen++;
      if (krn_ren === 1'b1) kr_seen++;
      if (in_ren === 1'b1) begin ir_seen++; last_in_addr = int'(in_addr); end
      if (busy === 1'b1) busy_seen++;
      if (done === 1'b1) begin done_cnt++; last_done_rel = rel; end
    end
  end

  task automatic clr_obs();
    kv_seen = 0; dv_seen = 0; kr_seen = 0; ir_seen = 0; busy_seen = 0;
    done_cnt = 0; last_done_rel = -1; last_in_addr = -1;
  endtask

  // Called at a falling edge; returns at the falling edge of rel 0.
  task automatic start_run(input int n, input bit to);
    prev_err   = cur_err(cyc);
    run_s      = cyc + 1;
    run_n      = n;
    run_to     = to;
    run_active = 1'b1;
    start      = 1'b1;
    num_tiles  = 8'(n);
    @(negedge clk);
    start      = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; num_tiles = '0;
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_ovf", ovf_err, 1'b0);
    chk("rst_tile", tile_idx, 8'd0);
    rst = 1'b0;
    @(negedge clk);

    // One tile
    clr_obs();
    start_run(1, 1'b0);
    repeat (95) @(negedge clk);
    chk("t1_done_rel", last_done_rel, 90);
    chk("t1_done_cnt", done_cnt, 1);
    chk("t1_kv_beats", kv_seen, 64);
    chk("t1_dv_beats", dv_seen, 8);
    chk("t1_last_in_addr", last_in_addr, 7);

    // Three tiles, with a start pulse while loading rows that must be ignored
    clr_obs();
    start_run(3, 1'b0);
    repeat (69) @(negedge clk);
    start = 1'b1; num_tiles = 8'd5;
    @(negedge clk);
    start = 1'b0; num_tiles = 8'd3;
    repeat (80) @(negedge clk);
    chk("t3_done_rel", last_done_rel, 142);
    chk("t3_done_cnt", done_cnt, 1);
    chk("t3_kv_beats", kv_seen, 64);
    chk("t3_dv_beats", dv_seen, 24);
    chk("t3_last_in_addr", last_in_addr, 23);
    chk("t3_err", err, 1'b0);

    // Zero tiles
    clr_obs();
    start_run(0, 1'b0);
    repeat (5) @(negedge clk);
    chk("t0_done_rel", last_done_rel, 0);
    chk("t0_done_cnt", done_cnt, 1);
    chk("t0_traffic", kr_seen + ir_seen + kv_seen + dv_seen, 0);
    chk("t0_busy_seen", busy_seen, 0);

    // Timeout with a silent datapath, then a fresh start clears err
    dp_en = 1'b0;
    clr_obs();
    start_run(1, 1'b1);
    repeat (110) @(negedge clk);
    chk("to_done_rel", last_done_rel, 105);
    chk("to_err", err, 1'b1);
    dp_en = 1'b1;
    start_run(1, 1'b0);
    chk("to_err_cleared", err, 1'b0);
    repeat (95) @(negedge clk);

    // Reset mid kernel load, then restart from kernel address 0
    start_run(1, 1'b0);
    repeat (20) @(negedge clk);
    chk("rs_pre_addr", krn_addr, 6'd20);
    rst = 1'b1;
    @(negedge clk);
    chk("rs_krn_addr", krn_addr, 6'd0);
    chk("rs_kvalid", kvalid, 1'b0);
    chk("rs_kdata", kdata, 128'd0);
    chk("rs_busy", busy, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    clr_obs();
    start_run(1, 1'b0);
    chk("rs_restart_addr", krn_addr, 6'd0);
    chk("rs_restart_ren", krn_ren, 1'b1);
    repeat (95) @(negedge clk);
    chk("rs_done_rel", last_done_rel, 90);

    // Stray outvalid while idle sets a sticky flag cleared only by reset
    stray_ov = 1'b1;
    @(negedge clk);
    stray_ov = 1'b0;
    @(negedge clk);
    chk("ovf_set", ovf_err, 1'b1);
    repeat (10) @(negedge clk);
    chk("ovf_hold", ovf_err, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("ovf_rst", ovf_err, 1'b0);
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
